// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - single-byte 7-bit-addressed I2C master; I2C_NACK_STATUS_EN adds a nack status port
module i2c_byte_master #(
    parameter int DIV_HALF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    output logic       i2c_scl
`ifdef I2C_NACK_STATUS_EN
    ,
    output logic       nack
`endif
);

    localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE_DATA, WDATA_ACK, READ_DATA, MACK, STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          scl_hi, scl_hi_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    wbyte, wbyte_n;
    logic          rw_q, rw_n;
    logic [7:0]    rx, rx_n;
    logic [7:0]    data_out_q, data_out_n;
    logic          ready_q, ready_n;
    logic          scl_q, scl_n;
    logic          sda_low_q, sda_low_n;
    logic          sda_in;
    logic          tick, rise, fall;
`ifdef I2C_NACK_STATUS_EN
    logic          nack_q, nack_n;
`endif

    assign sda_in = i2c_sda;
    assign tick   = (cnt == CW'(DIV_HALF - 1));
    // Bit phases: one tick raises SCL, the next ends the high phase (sample point, SDA may then change)
    assign rise   = tick && !scl_hi;
    assign fall   = tick && scl_hi;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            scl_hi     <= 1'b0;
            shift      <= '0;
            wbyte      <= '0;
            rw_q       <= 1'b0;
            rx         <= '0;
            data_out_q <= 8'h00;
            ready_q    <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
`ifdef I2C_NACK_STATUS_EN
            nack_q     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            scl_hi     <= scl_hi_n;
            shift      <= shift_n;
            wbyte      <= wbyte_n;
            rw_q       <= rw_n;
            rx         <= rx_n;
            data_out_q <= data_out_n;
            ready_q    <= ready_n;
            scl_q      <= scl_n;
            sda_low_q  <= sda_low_n;
`ifdef I2C_NACK_STATUS_EN
            nack_q     <= nack_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = (state == IDLE || tick) ? '0 : cnt + CW'(1);
        bit_cnt_n  = bit_cnt;
        scl_hi_n   = scl_hi;
        shift_n    = shift;
        wbyte_n    = wbyte;
        rw_n       = rw_q;
        rx_n       = rx;
        data_out_n = data_out_q;
        ready_n    = 1'b0;
        scl_n      = scl_q;
        sda_low_n  = sda_low_q;
`ifdef I2C_NACK_STATUS_EN
        nack_n     = nack_q;
`endif

        if (state != IDLE && state != START && state != STOP) begin
            if (rise) begin
                scl_n    = 1'b1;
                scl_hi_n = 1'b1;
            end
            if (fall) begin
                scl_n    = 1'b0;
                scl_hi_n = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
                ready_n   = 1'b1;
                if (ready_q && enable) begin
                    state_n   = START;
                    ready_n   = 1'b0;
                    shift_n   = {addr, rw};
                    wbyte_n   = data_in;
                    rw_n      = rw;
                    sda_low_n = 1'b1;
`ifdef I2C_NACK_STATUS_EN
                    nack_n    = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_n   = ADDR;
                    scl_n     = 1'b0;
                    scl_hi_n  = 1'b0;
                    bit_cnt_n = '0;
                    sda_low_n = ~shift[7];
                end
            end
            ADDR, WRITE_DATA: begin
                if (fall) begin
                    if (bit_cnt == 3'd7) begin
                        state_n   = (state == ADDR) ? ADDR_ACK : WDATA_ACK;
                        sda_low_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shift_n   = {shift[6:0], 1'b0};
                        sda_low_n = ~shift[6];
                    end
                end
            end
            ADDR_ACK: begin
                if (fall) begin
                    bit_cnt_n = '0;
                    if (!sda_in) begin
                        if (rw_q) begin
                            state_n   = READ_DATA;
                            sda_low_n = 1'b0;
                        end else begin
                            state_n   = WRITE_DATA;
                            shift_n   = wbyte;
                            sda_low_n = ~wbyte[7];
                        end
                    end else begin
                        state_n   = STOP;
                        sda_low_n = 1'b1;
`ifdef I2C_NACK_STATUS_EN
                        nack_n    = 1'b1;
`endif
                    end
                end
            end
            WDATA_ACK: begin
                if (fall) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    sda_low_n = 1'b1;
`ifdef I2C_NACK_STATUS_EN
                    if (sda_in) nack_n = 1'b1;
`endif
                end
            end
            READ_DATA: begin
                if (fall) begin
                    rx_n = {rx[6:0], sda_in};
                    if (bit_cnt == 3'd7) begin
                        state_n    = MACK;
                        data_out_n = {rx[6:0], sda_in};
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            MACK: begin
                if (fall) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    sda_low_n = 1'b1;
                end
            end
            STOP: begin
                // Three half-periods: SDA low/SCL low, SCL high, SDA released with SCL high
                if (tick) begin
                    case (bit_cnt)
                        3'd0: begin
                            scl_n     = 1'b1;
                            bit_cnt_n = 3'd1;
                        end
                        3'd1: begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = 3'd2;
                        end
                        default: begin
                            state_n = IDLE;
                            ready_n = 1'b1;
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
    assign i2c_scl  = scl_q;
    assign ready    = ready_q;
    assign data_out = data_out_q;
`ifdef I2C_NACK_STATUS_EN
    assign nack     = nack_q;
`endif

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - randomized bench for i2c_byte_master with a bus-level slave and reference model
module tb_i2c_byte_master;

    localparam int         DIV_HALF   = 2;
    localparam logic [6:0] SLAVE_ADDR = 7'h14;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       ready;
    logic       i2c_scl;
    wire        i2c_sda;
`ifdef I2C_NACK_STATUS_EN
    logic       nack;
`endif

    logic       slave_low = 1'b0;
    logic [7:0] slave_tx = 8'h00;

    assign i2c_sda = slave_low ? 1'b0 : 1'bz;
    pullup pu_sda (i2c_sda);

    always #5 clk = ~clk;

    i2c_byte_master #(.DIV_HALF(DIV_HALF)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .enable   (enable),
        .rw       (rw),
        .data_out (data_out),
        .ready    (ready),
        .i2c_sda  (i2c_sda),
        .i2c_scl  (i2c_scl)
`ifdef I2C_NACK_STATUS_EN
        ,
        .nack     (nack)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus observer and slave at SLAVE_ADDR; a SCL rise followed by STOP is not a data bit
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         starts = 0, stops = 0, k = 0, nbits = 0;
    logic [7:0] mon_addr = '0, mon_data = '0;
    logic       mon_ack1 = 1'b1, mon_ack2 = 1'b1;

    always @(posedge clk) begin
        logic scl_c, sda_c, matched;
        #1;
        scl_c = i2c_scl;
        sda_c = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
        if (!rst) begin
            k = 0;
            slave_low = 1'b0;
        end else if (scl_p && scl_c && sda_p && !sda_c) begin
            starts++;
            k = 0;
        end else if (scl_p && scl_c && !sda_p && sda_c) begin
            stops++;
            nbits = k - 1;
            slave_low = 1'b0;
        end else if (!scl_p && scl_c) begin
            k++;
            if (k <= 8)       mon_addr = {mon_addr[6:0], sda_c};
            else if (k == 9)  mon_ack1 = sda_c;
            else if (k <= 17) mon_data = {mon_data[6:0], sda_c};
            else if (k == 18) mon_ack2 = sda_c;
        end else if (scl_p && !scl_c) begin
            matched = (mon_addr[7:1] == SLAVE_ADDR);
            if (k == 8)                 slave_low = matched;
            else if (k >= 9 && k <= 16) slave_low = matched && mon_addr[0] && !slave_tx[3'(16 - k)];
            else if (k == 17)           slave_low = matched && !mon_addr[0];
            else                        slave_low = 1'b0;
        end
        scl_p = scl_c;
        sda_p = sda_c;
    end

    logic [7:0] ref_dout = 8'h00;

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input logic [7:0] tx, input bit toggle);
        int   s0, p0, lat;
        bit   busy, done;
        logic nacked;
        s0 = starts;
        p0 = stops;
        slave_tx = tx;
        @(negedge clk);
        addr = a; rw = r; data_in = d; enable = 1'b1;
        lat = 0; busy = 0; done = 0;
        while (!done && lat < 300) begin
            @(posedge clk);
            #2;
            lat++;
            if (!ready) busy = 1;
            else if (busy) done = 1;
            if (lat == 1) begin
                addr = 7'($urandom);
                data_in = 8'($urandom);
                rw = ~r;
            end
            if (toggle) enable = (lat < 30) ? lat[0] : 1'b0;
            else if (lat >= 5) enable = 1'b0;
        end
        nacked = (a != SLAVE_ADDR);
        check("txn_done", 32'(done), 32'd1);
        check("latency_le_90", 32'(lat <= 90), 32'd1);
        check("start_count", 32'(starts - s0), 32'd1);
        check("stop_count", 32'(stops - p0), 32'd1);
        check("addr_byte", 32'(mon_addr), 32'({a, r}));
        check("addr_ack", 32'(mon_ack1), 32'(nacked));
        check("bit_count", 32'(nbits), nacked ? 32'd9 : 32'd18);
        if (!nacked) begin
            check("data_byte", 32'(mon_data), 32'(r ? tx : d));
            check("data_ack", 32'(mon_ack2), 32'(r));
            if (r) ref_dout = tx;
        end
        check("data_out", 32'(data_out), 32'(ref_dout));
`ifdef I2C_NACK_STATUS_EN
        check("nack", 32'(nack), 32'(nacked));
`endif
        if (toggle) begin
            repeat (20) @(negedge clk);
            check("single_txn", 32'(starts - s0), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (50) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_scl", 32'(i2c_scl), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(ready), 32'd1);
        check("idle_scl", 32'(i2c_scl), 32'd1);
        check("idle_sda", 32'(i2c_sda === 1'b0 ? 1'b0 : 1'b1), 32'd1);
        check("reset_data_out", 32'(data_out), 32'h00);

        run_txn(7'h14, 1'b0, 8'hAA, 8'h00, 1'b0);
        run_txn(7'h14, 1'b1, 8'h00, 8'h5C, 1'b0);
        run_txn(7'h33, 1'b0, 8'h96, 8'h00, 1'b0);
        run_txn(7'h14, 1'b0, 8'h3C, 8'h00, 1'b1);
        run_txn(7'h14, 1'b1, 8'h00, 8'hA7, 1'b0);

        @(negedge clk);
        addr = 7'h14; rw = 1'b0; data_in = 8'h3C; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_scl", 32'(i2c_scl), 32'd1);
        check("abort_sda", 32'(i2c_sda === 1'b0 ? 1'b0 : 1'b1), 32'd1);
        check("abort_ready", 32'(ready), 32'd0);
        ref_dout = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_release", 32'(ready), 32'd1);
        run_txn(7'h14, 1'b0, 8'h81, 8'h00, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_txn(($urandom_range(0, 2) != 0) ? SLAVE_ADDR : 7'($urandom),
                    1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
Single-byte I2C bus master that performs one 7-bit-addressed write or read transaction per request. It sits between a local controller (addr/data/enable/ready handshake) and an open-drain I2C bus shared with one or more slaves. It generates START, address+R/W, data byte, ACK/NACK and STOP, with SCL derived from the system clock.

Parameters:
- DIV_HALF, 2, system-clock cycles per SCL half-period; SCL period = 2*DIV_HALF clk cycles; must be ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on next clk edge).
- addr  input  7  slave address; latched at transaction start.
- data_in  input  8  write byte; latched at transaction start.
- enable  input  1  start request; level-sampled only when idle.
- rw  input  1  0 = write, 1 = read; latched at transaction start.
- data_out  output  8  last byte read from the slave.
- ready  output  1  1 = idle and able to accept a request.
- i2c_sda  inout  1  open-drain SDA: drives 0 or releases to Z; external pull-up required.
- i2c_scl  output  1  SCL, push-pull; no clock stretching supported.

Behaviour:
- Reset (rst=0): state=IDLE, ready=0, data_out=8'h00, SDA released, SCL=1, divider cleared. ready rises on the first clk edge with rst=1.
- Divider: a tick is generated every DIV_HALF clk cycles. The FSM advances only on ticks. SCL toggles on ticks during bit phases. SDA changes only while SCL is low, except at START and STOP.
- IDLE: SCL=1, SDA released, ready=1. If enable=1 on a clk edge, latch addr/data_in/rw, set ready=0 on that same edge, and go to START.
- START: SDA is pulled low while SCL=1, held one half-period, then SCL goes low.
- ADDR: shift out {addr, rw} MSB first (8 bits), one bit per SCL period. A 0 bit drives SDA low; a 1 bit releases it.
- ADDR_ACK: release SDA and sample it on the SCL high phase. If 0 (ACK): go to WRITE_DATA when rw=0, or READ_DATA when rw=1. If 1 (NACK): go to STOP.
- WRITE_DATA: shift data_in MSB first, 8 bits. Then WDATA_ACK: release SDA, sample the ACK, then go to STOP regardless of the ACK value.
- READ_DATA: SDA released. Sample 8 bits MSB first on SCL high into a shift register. Then MACK: the master releases SDA (NACK = last byte). data_out is updated with the assembled byte at entry to MACK, then go to STOP.
- STOP: drive SDA low while SCL low, raise SCL, then release SDA while SCL=1. Hold one half-period, then go to IDLE, where ready=1.
- One byte per transaction; no repeated START. enable is ignored while ready=0. If enable is still high on return to IDLE, a new transaction starts immediately.
- data_out holds its value between reads and is unchanged by writes.
- Reset mid-transaction aborts immediately: bus lines released to idle (SDA Z, SCL 1). No STOP is generated.
- Transaction length: 20 SCL periods ±1 half-period. With DIV_HALF=2 this is ≤ 90 clk cycles.

Optional Feature:
- Macro I2C_NACK_STATUS_EN. When defined, add output port nack (1 bit). nack is cleared at transaction start and set if the address or write-data ACK was sampled as 1. It holds until the next transaction and is 0 after reset.
- When not defined, there is no nack port and NACKs are silently handled as described above.

Test Plan:
- Reset held low 50 clk, then released → ready=1 one clk later; SCL=1, SDA=Z(1), data_out=8'h00.
- Write: addr=7'h14, rw=0, data_in=8'hAA, enable pulsed 5 clk; slave model ACKs at 0x14 → SDA bit sequence 0x28 then 0xAA, START/STOP present, slave receives 0xAA, ready back to 1 within 90 clk.
- Read: addr=7'h14, rw=1; slave returns 8'h5C → address byte 0x29, master NACKs the data byte, data_out=8'h5C, then STOP and ready=1.
- Address NACK: addr=7'h33, no slave responds → STOP right after the address ACK slot, no data phase, ready=1; with I2C_NACK_STATUS_EN, nack=1.
- enable toggled while busy → ignored; exactly one transaction occurs; a following enable after ready=1 starts a new one.
- rst driven low mid-address phase → next clk SCL=1, SDA=Z, ready=0; after release ready=1 and a new write completes correctly.
